// File: rtl/heichips25_spi_pkg.sv
// Shared types and constants for the SPI flash reader.
// HEICHIPS25_SPI_FAST_READ_EN adds the DUMMY state used by the fast-read opcode.
package heichips25_spi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
`ifdef HEICHIPS25_SPI_FAST_READ_EN
        ST_DUMMY,
`endif
        ST_DATA,
        ST_HOLD,
        ST_DESEL
    } state_e;

    localparam logic [7:0] OP_READ      = 8'h03;
    localparam logic [7:0] OP_FAST_READ = 8'h0B;
    localparam int         ADDR_BITS    = 24;
    localparam int         DUMMY_CYCLES = 8;

endpackage

// File: rtl/heichips25_spi_clkgen.sv
// SCLK divider: each half-period lasts CLK_DIV clk_i cycles; run_i=0 freezes SCLK
// in place, clr_i returns it to the idle-low phase with a fresh half-period.
module heichips25_spi_clkgen #(
    parameter int CLK_DIV = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic run_i,
    output logic sclk_o,
    output logic rise_o,
    output logic fall_o
);

    logic [7:0] cnt_q, cnt_d;
    logic       sclk_q, sclk_d;
    logic       half_end;

    // Strobes are high in the last cycle of a half; the register toggles on that edge.
    always_comb begin
        half_end = run_i && (cnt_q == 8'(CLK_DIV - 1));
        rise_o   = half_end && !sclk_q;
        fall_o   = half_end && sclk_q;
        cnt_d    = cnt_q;
        sclk_d   = sclk_q;
        if (clr_i) begin
            cnt_d  = 8'd0;
            sclk_d = 1'b0;
        end else if (half_end) begin
            cnt_d  = 8'd0;
            sclk_d = !sclk_q;
        end else if (run_i) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q  <= 8'd0;
            sclk_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            sclk_q <= sclk_d;
        end
    end

    assign sclk_o = sclk_q;

endmodule

// File: rtl/heichips25_spi_flash_reader.sv
// SPI mode-0 host reading a byte stream from NOR flash into a valid/ready stream.
// HEICHIPS25_SPI_FAST_READ_EN selects opcode 0x0B with 8 dummy clocks; default is 0x03.
// Stream handshake: data_o is transferred on every cycle where valid_o && ready_i;
// valid_o stays high with data_o stable until that happens.
module heichips25_spi_flash_reader
    import heichips25_spi_pkg::*;
#(
    parameter int CLK_DIV = 2,
    parameter int LEN_W   = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [23:0]      addr_i,
    input  logic [LEN_W-1:0] len_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [7:0]       data_o,
    output logic             valid_o,
    input  logic             ready_i,
    output logic             sclk_o,
    output logic             sclk_en_o,
    output logic             cs_n_o,
    output logic             cs_n_en_o,
    output logic             mosi_o,
    output logic             mosi_en_o,
    input  logic             miso_i
);

`ifdef HEICHIPS25_SPI_FAST_READ_EN
    localparam logic [7:0] OPCODE = OP_FAST_READ;
`else
    localparam logic [7:0] OPCODE = OP_READ;
`endif
    localparam logic [8:0] DESEL_LAST = 9'(2 * CLK_DIV - 1);

    state_e           state_q, state_d;
    logic [31:0]      tx_q, tx_d;
    logic [7:0]       rx_q, rx_d;
    logic [4:0]       bit_q, bit_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic             full_q, full_d;
    logic [7:0]       data_q, data_d;
    logic             valid_q, valid_d;
    logic             done_q, done_d;
    logic             zlen_q, zlen_d;
    logic [8:0]       desel_q, desel_d;
    logic             can_xfer, clk_run, clk_clr, sclk_rise, sclk_fall;

    heichips25_spi_clkgen #(.CLK_DIV(CLK_DIV)) u_clkgen (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .clr_i  (clk_clr),
        .run_i  (clk_run),
        .sclk_o (sclk_o),
        .rise_o (sclk_rise),
        .fall_o (sclk_fall)
    );

    always_comb begin
        state_d  = state_q;
        tx_d     = tx_q;
        rx_d     = rx_q;
        bit_d    = bit_q;
        cnt_d    = cnt_q;
        full_d   = full_q;
        data_d   = data_q;
        valid_d  = valid_q;
        done_d   = 1'b0;
        zlen_d   = 1'b0;
        desel_d  = desel_q;
        clk_run  = 1'b0;
        clk_clr  = (state_q == ST_IDLE);
        can_xfer = !valid_q || ready_i;

        if (valid_q && ready_i) valid_d = 1'b0;
        if (full_q && can_xfer) begin
            data_d  = rx_q;
            valid_d = 1'b1;
            full_d  = 1'b0;
        end
        // bit_q counts SCLK rises in the current phase; phases end on the matching fall.
        if (sclk_rise) bit_d = bit_q + 5'd1;

        case (state_q)
            ST_IDLE: begin
                bit_d   = 5'd0;
                desel_d = 9'd0;
                if (start_i && !zlen_q) begin
                    if (len_i == '0) begin
                        zlen_d = 1'b1;
                        done_d = 1'b1;
                    end else begin
                        state_d = ST_CMD;
                        tx_d    = {OPCODE, addr_i};
                        cnt_d   = len_i;
                    end
                end
            end
            ST_CMD, ST_ADDR: begin
                clk_run = 1'b1;
                if (sclk_fall) begin
                    tx_d = {tx_q[30:0], 1'b0};
                    if (state_q == ST_CMD && bit_q == 5'd8) begin
                        bit_d   = 5'd0;
                        state_d = ST_ADDR;
                    end else if (state_q == ST_ADDR && bit_q == 5'(ADDR_BITS)) begin
                        bit_d = 5'd0;
`ifdef HEICHIPS25_SPI_FAST_READ_EN
                        state_d = ST_DUMMY;
`else
                        state_d = ST_DATA;
`endif
                    end
                end
            end
`ifdef HEICHIPS25_SPI_FAST_READ_EN
            ST_DUMMY: begin
                clk_run = 1'b1;
                if (sclk_fall && bit_q == 5'(DUMMY_CYCLES)) begin
                    bit_d   = 5'd0;
                    state_d = ST_DATA;
                end
            end
`endif
            ST_DATA: begin
                if (full_q && !can_xfer) begin
                    state_d = ST_HOLD;
                end else begin
                    clk_run = 1'b1;
                    if (sclk_fall) begin
                        rx_d = {rx_q[6:0], miso_i};
                        if (bit_q == 5'd8) begin
                            bit_d  = 5'd0;
                            full_d = 1'b1;
                            cnt_d  = cnt_q - 1'b1;
                            if (cnt_q == LEN_W'(1)) state_d = ST_DESEL;
                        end
                    end
                end
            end
            ST_HOLD: begin
                if (can_xfer) state_d = ST_DATA;
            end
            ST_DESEL: begin
                if (desel_q != DESEL_LAST) desel_d = desel_q + 9'd1;
                if (desel_q == DESEL_LAST && !full_q && can_xfer) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            tx_q    <= 32'd0;
            rx_q    <= 8'd0;
            bit_q   <= 5'd0;
            cnt_q   <= '0;
            full_q  <= 1'b0;
            data_q  <= 8'h00;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            zlen_q  <= 1'b0;
            desel_q <= 9'd0;
        end else begin
            state_q <= state_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
            bit_q   <= bit_d;
            cnt_q   <= cnt_d;
            full_q  <= full_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            done_q  <= done_d;
            zlen_q  <= zlen_d;
            desel_q <= desel_d;
        end
    end

    assign busy_o    = (state_q != ST_IDLE) || zlen_q;
    assign done_o    = done_q;
    assign data_o    = data_q;
    assign valid_o   = valid_q;
    assign cs_n_o    = (state_q == ST_IDLE) || (state_q == ST_DESEL);
    assign cs_n_en_o = (state_q != ST_IDLE);
    assign sclk_en_o = (state_q != ST_IDLE);
    assign mosi_en_o = (state_q != ST_IDLE);
    assign mosi_o    = tx_q[31] && ((state_q == ST_CMD) || (state_q == ST_ADDR));

endmodule

// File: tb/tb_heichips25_spi_flash_reader.sv
// Directed bench for heichips25_spi_flash_reader with a behavioural SPI flash and
// a stream scoreboard; builds with or without HEICHIPS25_SPI_FAST_READ_EN.
module tb_heichips25_spi_flash_reader;

  localparam int CLK_DIV = 2;
  localparam int LEN_W   = 16;
`ifdef HEICHIPS25_SPI_FAST_READ_EN
  localparam int         HDR       = 40;
  localparam logic [7:0] OPC       = 8'h0B;
  localparam int         FIRST_LAT = 193;
`else
  localparam int         HDR       = 32;
  localparam logic [7:0] OPC       = 8'h03;
  localparam int         FIRST_LAT = 161;
`endif

  logic clk = 1'b0;
  logic rst_i, start_i, ready_i, miso_i;
  logic [23:0] addr_i;
  logic [LEN_W-1:0] len_i;
  logic busy_o, done_o, valid_o;
  logic [7:0] data_o;
  logic sclk_o, sclk_en_o, cs_n_o, cs_n_en_o, mosi_o, mosi_en_o;

  heichips25_spi_flash_reader #(.CLK_DIV(CLK_DIV), .LEN_W(LEN_W)) dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .addr_i(addr_i), .len_i(len_i),
    .busy_o(busy_o), .done_o(done_o), .data_o(data_o), .valid_o(valid_o),
    .ready_i(ready_i), .sclk_o(sclk_o), .sclk_en_o(sclk_en_o), .cs_n_o(cs_n_o),
    .cs_n_en_o(cs_n_en_o), .mosi_o(mosi_o), .mosi_en_o(mosi_en_o), .miso_i(miso_i)
  );

  // clock / reset
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // flash content: byte at address a is a[7:0] + 0x5B (0x012345 -> 0xA0)
  function automatic logic [7:0] flash_byte(input logic [23:0] a);
    return a[7:0] + 8'h5B;
  endfunction

  // behavioural flash: captures opcode+address on SCLK rises, shifts data on falls
  int rise_cnt = 0;
  logic [31:0] cap = 32'd0;
  int fn;
  logic [7:0] fb;
  initial miso_i = 1'b0;
  always @(posedge sclk_o or negedge cs_n_o) begin
    if (!sclk_o) begin
      rise_cnt = 0;
      cap = 32'd0;
    end else if (!cs_n_o) begin
      if (rise_cnt < 32) cap = {cap[30:0], mosi_o};
      rise_cnt = rise_cnt + 1;
    end
  end
  always @(negedge sclk_o) begin
    if (!cs_n_o && rise_cnt >= HDR) begin
      fn = rise_cnt - HDR;
      fb = flash_byte(cap[23:0] + 24'(fn / 8));
      miso_i <= fb[7 - (fn % 8)];
    end
  end

  // scoreboard
  logic [7:0] exp_q[$];
  logic [7:0] acc_data[$];
  int acc_cyc[$];
  int done_cnt, cs_fall_cyc, first_valid_cyc;
  logic en_seen, exp_busy_at_done;

  always @(negedge clk) begin
    if (!rst_i) begin
      if (valid_o && ready_i) begin
        acc_data.push_back(data_o);
        acc_cyc.push_back(cyc);
        if (exp_q.size() == 0) check("extra_byte", {24'd0, data_o}, 32'hFFFF_FFFF);
        else check("stream_data", {24'd0, data_o}, {24'd0, exp_q.pop_front()});
      end
      if (!cs_n_en_o) check("idle_pins", {27'd0, sclk_o, cs_n_o, mosi_o, sclk_en_o, mosi_en_o}, 32'b01000);
      else begin
        en_seen = 1'b1;
        check("en_while_busy", {29'd0, busy_o, sclk_en_o, mosi_en_o}, 32'b111);
      end
      if (!cs_n_o && cs_fall_cyc < 0) cs_fall_cyc = cyc;
      if (valid_o && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (done_o) begin
        done_cnt++;
        check("busy_at_done", {31'd0, busy_o}, {31'd0, exp_busy_at_done});
      end
    end
  end

  // driver tasks
  task automatic new_xfer(input logic busy_at_done);
    done_cnt = 0; cs_fall_cyc = -1; first_valid_cyc = -1; en_seen = 1'b0;
    acc_data.delete(); acc_cyc.delete();
    exp_busy_at_done = busy_at_done;
  endtask

  task automatic do_start(input logic [23:0] a, input logic [LEN_W-1:0] l);
    @(posedge clk); #1;
    if (!busy_o) for (int i = 0; i < int'(l); i++) exp_q.push_back(flash_byte(a + 24'(i)));
    addr_i = a; len_i = l; start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (done_cnt == 0 && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    if (done_cnt == 0) check("done_timeout", 32'd0, 32'd1);
    repeat (6) @(posedge clk);
    #1;
  endtask

  task automatic check_end(input string tag, input logic [23:0] a, input int nbytes);
    check({tag, "_cmd"}, cap, {OPC, a});
    check({tag, "_nbytes"}, acc_data.size(), nbytes);
    check({tag, "_left"}, exp_q.size(), 0);
    check({tag, "_done_cnt"}, done_cnt, 1);
    check({tag, "_idle"}, {29'd0, busy_o, cs_n_o, cs_n_en_o}, 32'b010);
  endtask

  initial begin
    int spin;
    rst_i = 1'b1; start_i = 1'b0; ready_i = 1'b1; addr_i = 24'd0; len_i = '0;
    new_xfer(1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("rst_pins", {26'd0, sclk_o, cs_n_o, mosi_o, sclk_en_o, cs_n_en_o, mosi_en_o}, 32'b010000);
    check("rst_status", {29'd0, busy_o, done_o, valid_o}, 32'd0);
    check("rst_data", {24'd0, data_o}, 32'h00);
    rst_i = 1'b0;

    // unstalled 4-byte read
    new_xfer(1'b0);
    do_start(24'h012345, 16'd4);
    check("cs_fall_after_start", {30'd0, cs_n_o, mosi_o}, {30'd0, 1'b0, OPC[7]});
    wait_done(2000);
    check_end("t1", 24'h012345, 4);
    check("t1_cmd_lit", cap, (HDR == 32) ? 32'h03012345 : 32'h0B012345);
    check("t1_first_lat", first_valid_cyc - cs_fall_cyc, FIRST_LAT);
    if (acc_data.size() == 4) begin
      check("t1_byte0", {24'd0, acc_data[0]}, 32'hA0);
      check("t1_byte3", {24'd0, acc_data[3]}, 32'hA3);
      check("t1_spacing", acc_cyc[1] - acc_cyc[0], 16 * CLK_DIV);
      check("t1_spacing2", acc_cyc[3] - acc_cyc[2], 16 * CLK_DIV);
    end

    // 100-cycle stall after the first byte
    new_xfer(1'b0);
    do_start(24'h012345, 16'd4);
    spin = 0;
    while (!valid_o && spin < 1000) begin
      @(posedge clk); #1;
      spin++;
    end
    ready_i = 1'b0;
    check("t2_valid_seen", {31'd0, valid_o}, 32'd1);
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (i == 40 || i == 70 || i == 99) begin
        check("t2_stall_pins", {30'd0, sclk_o, cs_n_o}, 32'b00);
        check("t2_stall_hold", {23'd0, valid_o, data_o}, {23'd0, 1'b1, 8'hA0});
      end
    end
    ready_i = 1'b1;
    wait_done(2000);
    check_end("t2", 24'h012345, 4);
    if (acc_data.size() == 4) check("t2_byte1", {24'd0, acc_data[1]}, 32'hA1);

    // zero-length request
    new_xfer(1'b1);
    do_start(24'h00ABCD, 16'd0);
    check("t3_done_busy", {30'd0, done_o, busy_o}, 32'b11);
    @(posedge clk); #1;
    check("t3_after", {30'd0, done_o, busy_o}, 32'b00);
    repeat (4) @(posedge clk);
    #1;
    check("t3_no_enable", {31'd0, en_seen}, 32'd0);
    check("t3_done_cnt", done_cnt, 1);

    // reset in the middle of the address phase
    new_xfer(1'b0);
    do_start(24'h012345, 16'd4);
    repeat (50) @(posedge clk);
    #1;
    rst_i = 1'b1;
    @(posedge clk); #1;
    check("t4_rst_pins", {26'd0, sclk_o, cs_n_o, mosi_o, sclk_en_o, cs_n_en_o, mosi_en_o}, 32'b010000);
    check("t4_rst_status", {30'd0, busy_o, valid_o}, 32'd0);
    rst_i = 1'b0;
    exp_q.delete();
    check("t4_no_bytes", acc_data.size(), 0);

    // start pulsed while busy is ignored
    new_xfer(1'b0);
    do_start(24'h012345, 16'd2);
    repeat (20) @(posedge clk);
    do_start(24'hABCDEF, 16'd7);
    wait_done(2000);
    check_end("t5", 24'h012345, 2);

    // single byte from address zero
    new_xfer(1'b0);
    do_start(24'h000000, 16'd1);
    wait_done(2000);
    check_end("t6", 24'h000000, 1);
    if (acc_data.size() == 1) check("t6_byte", {24'd0, acc_data[0]}, 32'h5B);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
